// File: rtl/program_loader_pkg.sv
// Shared types and default constants for the instruction-memory program loader.
// Imported by the interface, the loader and the testbench.
package program_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam int          DEF_DATA_W     = 16;
    localparam int          DEF_ADDR_W     = 32;
    localparam int          DEF_DEPTH      = 1024;
    localparam logic [31:0] DEF_BASE       = 32'h20;
    localparam int          DEF_RESET_HOLD = 2;

endpackage

// File: rtl/program_loader_if.sv
// Bundle of the loader's control, source-stream, memory-write and status signals.
// The master side drives the session controls and the word stream; the loader sits on the slave side.
interface program_loader_if #(
    parameter int DATA_W = program_loader_pkg::DEF_DATA_W,
    parameter int ADDR_W = program_loader_pkg::DEF_ADDR_W,
    parameter int DEPTH  = program_loader_pkg::DEF_DEPTH
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              start;
    logic              use_default;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  word_count;

    modport master (
        output start, use_default, base_addr, in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, overflow, word_count
    );

    modport slave (
        input  start, use_default, base_addr, in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, overflow, word_count
    );

endinterface

// File: rtl/program_loader.sv
// Boot loader: streams program words into instruction memory from a latched base address
// while holding the processor in reset, then releases it a fixed number of cycles after the last write.
module program_loader #(
    parameter int                 DATA_W       = program_loader_pkg::DEF_DATA_W,
    parameter int                 ADDR_W       = program_loader_pkg::DEF_ADDR_W,
    parameter int                 DEPTH        = program_loader_pkg::DEF_DEPTH,
    parameter logic [ADDR_W-1:0]  BASE_DEFAULT = ADDR_W'(program_loader_pkg::DEF_BASE),
    parameter int                 RESET_HOLD   = program_loader_pkg::DEF_RESET_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus
);
    import program_loader_pkg::*;

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic              in_ready_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              cpu_reset_reg;
    logic              done_reg;
    logic              overflow_reg;

    logic              accept;
    logic [CNT_W-1:0]  count_inc;

    assign accept    = (state_reg == LOAD) && in_ready_reg && bus.in_valid;
    assign count_inc = count_reg + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            count_reg     <= '0;
            hold_reg      <= '0;
            in_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                IDLE, RUN: begin
                    if (bus.start) begin
                        base_reg      <= bus.use_default ? BASE_DEFAULT : bus.base_addr;
                        count_reg     <= '0;
                        overflow_reg  <= 1'b0;
                        hold_reg      <= '0;
                        cpu_reset_reg <= 1'b1;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // Address uses the pre-increment count; wraps modulo 2^ADDR_W.
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= base_reg + ADDR_W'(count_reg);
                        mem_wdata_reg <= bus.in_data;
                        count_reg     <= count_inc;
                        if (bus.in_last || (count_inc == CNT_W'(DEPTH))) begin
                            state_reg    <= HOLD;
                            in_ready_reg <= 1'b0;
                            overflow_reg <= !bus.in_last;
                            hold_reg     <= '0;
                        end
                    end
                end
                HOLD: begin
                    // Count 0 coincides with the final memory write.
                    if (hold_reg == HOLD_W'(RESET_HOLD - 1)) begin
                        state_reg     <= RUN;
                        done_reg      <= 1'b1;
                        cpu_reset_reg <= 1'b0;
                    end else begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.cpu_reset  = cpu_reset_reg;
    assign bus.busy       = (state_reg == LOAD) || (state_reg == HOLD);
    assign bus.done       = done_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.word_count = count_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (DEPTH=4, RESET_HOLD=2, default base 0x20).
module tb_program_loader;

    logic clk;
    logic reset;

    program_loader_if #(.DATA_W(16), .ADDR_W(32), .DEPTH(4)) bus ();

    program_loader #(
        .DATA_W(16), .ADDR_W(32), .DEPTH(4), .BASE_DEFAULT(32'h20), .RESET_HOLD(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [31:0] wa_q[$];
    logic [15:0] wd_q[$];

    int          gaps[4]    = '{0, 2, 1, 3};
    logic [15:0] def_data[3] = '{16'h413F, 16'h4AFF, 16'hCAFF};

    // Write log: one line per memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            $display("write addr=%08h data=%04h", bus.mem_addr, bus.mem_wdata);
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input bit ud, input logic [31:0] ba);
        bus.start = 1'b1;
        bus.use_default = ud;
        bus.base_addr = ba;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_run(output bit ok);
        for (int i = 0; i < 20; i++) begin
            if (bus.cpu_reset === 1'b0) break;
            tick();
        end
        ok = (bus.cpu_reset === 1'b0);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.cpu_reset !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_reset got %b want 1", bus.cpu_reset); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.done); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got %b want 0", bus.overflow); end
        n_cmp++; if (bus.word_count !== 3'd0) begin n_bad++; $display("FAIL rst_word_count got %0d want 0", bus.word_count); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 16'h0) begin n_bad++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin n_bad++; $display("FAIL idle_after_rst got rdy=%b cpu_rst=%b want 0/1", bus.in_ready, bus.cpu_reset); end
    endtask

    task automatic test_default_load();
        clear_log();
        start_session(1'b1, 32'h0);
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL def_load_entry got rdy=%b busy=%b want 1/1", bus.in_ready, bus.busy); end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = def_data[i];
            bus.in_last = (i == 2);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h22) begin n_bad++; $display("FAIL def_last_write got we=%b addr=%h want 1/22", bus.mem_we, bus.mem_addr); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL def_hold_ready got %b want 0", bus.in_ready); end
        tick();
        n_cmp++; if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0) begin n_bad++; $display("FAIL def_hold1 got cpu_rst=%b done=%b want 1/0", bus.cpu_reset, bus.done); end
        tick();
        n_cmp++; if (bus.cpu_reset !== 1'b0 || bus.done !== 1'b1) begin n_bad++; $display("FAIL def_release got cpu_rst=%b done=%b want 0/1", bus.cpu_reset, bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL def_run_busy got %b want 0", bus.busy); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL def_done_width got %b want 0", bus.done); end
        n_cmp++; if (wa_q.size() !== 3) begin n_bad++; $display("FAIL def_write_count got %0d want 3", wa_q.size()); end
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            n_cmp++; if (wa_q[i] !== 32'h20 + i || wd_q[i] !== def_data[i]) begin n_bad++; $display("FAIL def_write%0d got %h/%h want %h/%h", i, wa_q[i], wd_q[i], 32'h20 + i, def_data[i]); end
        end
        n_cmp++; if (bus.word_count !== 3'd3) begin n_bad++; $display("FAIL def_word_count got %0d want 3", bus.word_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL def_overflow got %b want 0", bus.overflow); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL def_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic test_gaps();
        bit ok;
        clear_log();
        start_session(1'b0, 32'h100);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL gap_ready w%0d got %b want 1", i, bus.in_ready); end
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data = 16'hA000 + 16'(i);
            bus.in_last = (i == 3);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL gap_accept_ready w%0d got %b want 1", i, bus.in_ready); end
            tick();
            bus.in_valid = 1'b0;
            bus.in_last = 1'b0;
        end
        wait_run(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL gap_run_timeout got cpu_rst=%b want 0", bus.cpu_reset); end
        n_cmp++; if (wa_q.size() !== 4) begin n_bad++; $display("FAIL gap_write_count got %0d want 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_cmp++; if (wa_q[i] !== 32'h100 + i || wd_q[i] !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL gap_write%0d got %h/%h want %h/%h", i, wa_q[i], wd_q[i], 32'h100 + i, 16'hA000 + 16'(i)); end
        end
        n_cmp++; if (bus.overflow !== 1'b0 || bus.word_count !== 3'd4) begin n_bad++; $display("FAIL gap_status got ovf=%b cnt=%0d want 0/4", bus.overflow, bus.word_count); end
    endtask

    task automatic test_overflow();
        bit ok;
        int accepts = 0;
        clear_log();
        start_session(1'b1, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 16'h1000 + 16'(i);
            if (bus.in_ready === 1'b1) accepts++;
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (accepts !== 4) begin n_bad++; $display("FAIL ovf_accepts got %0d want 4", accepts); end
        wait_run(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_run_timeout got cpu_rst=%b want 0", bus.cpu_reset); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
        n_cmp++; if (wa_q.size() !== 4) begin n_bad++; $display("FAIL ovf_write_count got %0d want 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_cmp++; if (wa_q[i] !== 32'h20 + i || wd_q[i] !== 16'h1000 + 16'(i)) begin n_bad++; $display("FAIL ovf_write%0d got %h/%h want %h/%h", i, wa_q[i], wd_q[i], 32'h20 + i, 16'h1000 + 16'(i)); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ovf_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_log();
        start_session(1'b0, 32'hFFFF_FFFF);
        bus.in_valid = 1'b1;
        bus.in_data = 16'h1111;
        bus.in_last = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf_cleared got %b want 0", bus.overflow); end
        tick();
        bus.in_data = 16'h2222;
        bus.in_last = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        wait_run(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_run_timeout got cpu_rst=%b want 0", bus.cpu_reset); end
        n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL wrap_write_count got %0d want 2", wa_q.size()); end
        if (wa_q.size() == 2) begin
            n_cmp++; if (wa_q[0] !== 32'hFFFF_FFFF || wd_q[0] !== 16'h1111) begin n_bad++; $display("FAIL wrap_write0 got %h/%h want ffffffff/1111", wa_q[0], wd_q[0]); end
            n_cmp++; if (wa_q[1] !== 32'h0 || wd_q[1] !== 16'h2222) begin n_bad++; $display("FAIL wrap_write1 got %h/%h want 00000000/2222", wa_q[1], wd_q[1]); end
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        clear_log();
        start_session(1'b1, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_last = 1'b0;
        bus.in_data = 16'h5550;
        tick();
        bus.in_data = 16'h5551;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL mid_pre_we got %b want 1", bus.mem_we); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_rst_we got %b want 0", bus.mem_we); end
        n_cmp++; if (bus.cpu_reset !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_state got cpu_rst=%b busy=%b want 1/0", bus.cpu_reset, bus.busy); end
        n_cmp++; if (bus.word_count !== 3'd0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_count got cnt=%0d rdy=%b want 0/0", bus.word_count, bus.in_ready); end
        tick();
        reset = 1'b1;
        tick();
        clear_log();
        start_session(1'b0, 32'h40);
        bus.in_valid = 1'b1;
        bus.in_data = 16'h7777;
        bus.in_last = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        wait_run(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mid_restart_timeout got cpu_rst=%b want 0", bus.cpu_reset); end
        n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL mid_restart_writes got %0d want 1", wa_q.size()); end
        if (wa_q.size() == 1) begin
            n_cmp++; if (wa_q[0] !== 32'h40 || wd_q[0] !== 16'h7777) begin n_bad++; $display("FAIL mid_restart_write got %h/%h want 40/7777", wa_q[0], wd_q[0]); end
        end
    endtask

    task automatic test_reload_from_run();
        bit ok;
        tick();
        n_cmp++; if (bus.cpu_reset !== 1'b0) begin n_bad++; $display("FAIL reload_pre got cpu_rst=%b want 0", bus.cpu_reset); end
        clear_log();
        start_session(1'b1, 32'h0);
        n_cmp++; if (bus.cpu_reset !== 1'b1 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reload_entry got cpu_rst=%b rdy=%b want 1/1", bus.cpu_reset, bus.in_ready); end
        // start is held through LOAD and HOLD; neither may restart the session.
        bus.start = 1'b1;
        bus.use_default = 1'b0;
        bus.base_addr = 32'h300;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hBEEF;
        bus.in_last = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        tick();
        bus.start = 1'b0;
        wait_run(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL reload_run_timeout got cpu_rst=%b want 0", bus.cpu_reset); end
        tick();
        tick();
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.cpu_reset !== 1'b0) begin n_bad++; $display("FAIL reload_stays_run got rdy=%b cpu_rst=%b want 0/0", bus.in_ready, bus.cpu_reset); end
        n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL reload_writes got %0d want 1", wa_q.size()); end
        if (wa_q.size() == 1) begin
            n_cmp++; if (wa_q[0] !== 32'h20 || wd_q[0] !== 16'hBEEF) begin n_bad++; $display("FAIL reload_write got %h/%h want 20/beef", wa_q[0], wd_q[0]); end
        end
        n_cmp++; if (done_cnt !== 1 || bus.word_count !== 3'd1) begin n_bad++; $display("FAIL reload_done got pulses=%0d cnt=%0d want 1/1", done_cnt, bus.word_count); end
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.use_default = 1'b0;
        bus.base_addr = 32'h0;
        bus.in_valid = 1'b0;
        bus.in_data = 16'h0;
        bus.in_last = 1'b0;
        test_reset();
        test_default_load();
        test_gaps();
        test_overflow();
        test_wrap();
        test_reset_mid_load();
        test_reload_from_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Parametrised boot-time loader for instruction memory. It streams program words from a valid/ready source into instruction memory at consecutive addresses from a programmable base, and holds the processor in reset for the whole session. After the last word it keeps reset asserted for a programmable number of cycles, then releases the processor. It sits between the external program source and the processor's memory write port and reset input, and replaces ad-hoc bench-driven loading and reset pulsing.

Parameters:
DATA_W, 16, width of one program word
ADDR_W, 32, instruction-memory address width
DEPTH, 1024, maximum words per session (>=1)
BASE_DEFAULT, 32'h20, base address used when start is pulsed with use_default=1
RESET_HOLD, 2, cycles cpu_reset stays high after the last write commits (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a load session (honoured only in IDLE or RUN)
use_default  in  1  sampled with start: 1 = use BASE_DEFAULT, 0 = use base_addr
base_addr  in  ADDR_W  session base address, sampled with start
in_valid  in  1  source word valid
in_data  in  DATA_W  program word
in_last  in  1  marks the final word of the program
in_ready  out  1  loader accepts a word this cycle
mem_we  out  1  instruction-memory write enable
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
cpu_reset  out  1  active-high processor reset
busy  out  1  high in LOAD or HOLD
done  out  1  one-cycle pulse on entry to RUN
overflow  out  1  sticky; session hit DEPTH without in_last
word_count  out  clog2(DEPTH+1)  words accepted in the current or last session

Behaviour:
- Reset (async, active-low): state=IDLE, cpu_reset=1, mem_we=0, in_ready=0, busy=0, done=0, overflow=0, word_count=0, mem_addr=0, mem_wdata=0, hold counter=0. Any in-flight write is dropped.
- States:
  - IDLE: cpu_reset=1, in_ready=0.
  - LOAD: in_ready=1, cpu_reset=1.
  - HOLD: in_ready=0, cpu_reset=1; counts RESET_HOLD cycles.
  - RUN: cpu_reset=0.
- IDLE/RUN + start=1: latch base (BASE_DEFAULT if use_default, else base_addr), clear word_count and overflow, go to LOAD next cycle. cpu_reset rises the same edge when leaving RUN.
- start is ignored in LOAD and HOLD.
- LOAD acceptance: a word is accepted when in_valid && in_ready. On the next cycle mem_we=1, mem_addr=base+word_count_old (mod 2^ADDR_W, wraps silently), mem_wdata=word. Write latency is one cycle. Otherwise mem_we=0.
- word_count increments on each accepted word.
- Session end: an accepted word with in_last=1, or the accepted word that makes word_count==DEPTH, moves to HOLD next cycle. That final word is still written.
- If the session ends on DEPTH without in_last, overflow=1 (sticky until next start or reset).
- Back-to-back accepts are allowed at one word per cycle. Source gaps (in_valid=0) stall without a timeout.
- HOLD: the counter runs from 0 to RESET_HOLD-1, starting the cycle the last mem_we is high. Then state=RUN, done=1 for exactly that cycle, cpu_reset=0 from that cycle.
- reset asserted mid-LOAD or mid-HOLD: immediate return to reset values. The processor stays in reset. Partially written memory is not cleaned.

Decomposition:
- Shared package: state enum (IDLE, LOAD, HOLD, RUN) and the default constants (DATA_W=16, ADDR_W=32, BASE_DEFAULT=32'h20).
- No sub-module. FSM, address adder and hold counter are kept inline; the hold counter is too small to justify its own block.

Test Plan:
- Load, defaults: start+use_default, stream 16'h413F, 16'h4AFF, 16'hCAFF (last) with in_valid held high -> writes at 0x20, 0x21, 0x22 on consecutive cycles; cpu_reset falls 2 cycles after the 0x22 write; done pulses once; word_count=3; overflow=0.
- Backpressure/gaps: base_addr=0x100, 4 words with in_valid low 1-3 cycles between them -> exactly 4 writes at 0x100-0x103; no write during gaps; in_ready stays 1 throughout LOAD.
- Overflow: DEPTH=4, 6 words offered with no in_last -> 4 writes; in_ready drops after the 4th accept; overflow=1; RUN is still reached; words 5-6 are never accepted.
- Wrap: base_addr=32'hFFFF_FFFF, 2 words -> writes at 0xFFFFFFFF then 0x00000000.
- Reset mid-load: reset low after the 2nd accept -> mem_we=0 immediately; cpu_reset=1; state IDLE; word_count=0. After release, a new start works normally.
- Reload from RUN: start in RUN with 1 word (last) -> cpu_reset rises next edge; single write; done pulses again; start asserted during LOAD or HOLD has no effect.
